// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch stage.
//   Drives the external PC register (pc_en_o/pc_next_o), fetches one word per
//   request from instruction memory and holds it for decode. A redirect from
//   execute squashes any wrong-path fetch in flight.
//   Optional misaligned-fetch trap: define IF_FETCH_ALIGN_CHK_EN.
//
// Handshakes (strict valid/ready):
//   imem  : imem_req_o stays high with imem_addr_o stable until the cycle
//           imem_ack_i=1, and imem_rdata_i is taken in that same cycle.
//           Reset may drop imem_req_o without an ack.
//   decode: if_valid_o with if_instr_o/if_pc_o/if_fault_o held stable until a
//           cycle with if_ready_i=1 (transfer). A fault entry stays valid
//           until a redirect, whatever if_ready_i does.
module if_fetch #(
   parameter int unsigned INSTR_BYTES = 4
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic [31:0] pc_i,
   output logic        pc_en_o,
   output logic [31:0] pc_next_o,
   input  logic        br_taken_i,
   input  logic [31:0] br_target_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ack_i,
   input  logic [31:0] imem_rdata_i,
   output logic        if_valid_o,
   input  logic        if_ready_i,
   output logic [31:0] if_instr_o,
   output logic [31:0] if_pc_o,
   output logic        if_fault_o,
   output logic [1:0]  dbg_state_o
);

   typedef enum logic [1:0] {
      S_ISSUE = 2'd0,
      S_WAIT  = 2'd1,
      S_HOLD  = 2'd2
`ifdef IF_FETCH_ALIGN_CHK_EN
      , S_FAULT = 2'd3
`endif
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] addr_q,  addr_d;
   logic        kill_q,  kill_d;
   logic        valid_q, valid_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] ifpc_q,  ifpc_d;

`ifdef IF_FETCH_ALIGN_CHK_EN
   logic        fault_q, fault_d;
   logic        misaligned;

   // A word fetch needs a 4-byte aligned address.
   assign misaligned = (pc_i[1:0] != 2'b00);
`endif

   // State and output registers.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= S_ISSUE;
         addr_q  <= '0;
         kill_q  <= 1'b0;
         valid_q <= 1'b0;
         instr_q <= '0;
         ifpc_q  <= '0;
`ifdef IF_FETCH_ALIGN_CHK_EN
         fault_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         kill_q  <= kill_d;
         valid_q <= valid_d;
         instr_q <= instr_d;
         ifpc_q  <= ifpc_d;
`ifdef IF_FETCH_ALIGN_CHK_EN
         fault_q <= fault_d;
`endif
      end
   end

   // Next-state and PC update; a redirect always wins over the sequential step.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      kill_d    = kill_q;
      valid_d   = valid_q;
      instr_d   = instr_q;
      ifpc_d    = ifpc_q;
`ifdef IF_FETCH_ALIGN_CHK_EN
      fault_d   = fault_q;
`endif
      pc_en_o   = 1'b0;
      pc_next_o = '0;

      case (state_q)
         S_ISSUE: begin
            if (br_taken_i) begin
               // The PC changes at this edge, so it is not latched yet.
               pc_en_o   = 1'b1;
               pc_next_o = br_target_i;
            end
`ifdef IF_FETCH_ALIGN_CHK_EN
            else if (misaligned) begin
               state_d = S_FAULT;
               valid_d = 1'b1;
               fault_d = 1'b1;
               instr_d = '0;
               ifpc_d  = pc_i;
            end
`endif
            else begin
               addr_d  = pc_i;
               state_d = S_WAIT;
            end
         end

         S_WAIT: begin
            if (imem_ack_i) begin
               if (kill_q || br_taken_i) begin
                  // Wrong-path data: drop it and refetch from the new PC.
                  kill_d  = 1'b0;
                  state_d = S_ISSUE;
                  if (br_taken_i) begin
                     pc_en_o   = 1'b1;
                     pc_next_o = br_target_i;
                  end
               end else begin
                  instr_d   = imem_rdata_i;
                  ifpc_d    = addr_q;
                  valid_d   = 1'b1;
                  pc_en_o   = 1'b1;
                  pc_next_o = addr_q + 32'(INSTR_BYTES);
                  state_d   = S_HOLD;
               end
            end else if (br_taken_i) begin
               // Request must stay stable, so remember to discard its data.
               pc_en_o   = 1'b1;
               pc_next_o = br_target_i;
               kill_d    = 1'b1;
            end
         end

         S_HOLD: begin
            if (br_taken_i) begin
               pc_en_o   = 1'b1;
               pc_next_o = br_target_i;
               valid_d   = 1'b0;
               state_d   = S_ISSUE;
            end
`ifdef IF_FETCH_ALIGN_CHK_EN
            else if (if_ready_i && misaligned) begin
               state_d = S_FAULT;
               valid_d = 1'b1;
               fault_d = 1'b1;
               instr_d = '0;
               ifpc_d  = pc_i;
            end
`endif
            else if (if_ready_i) begin
               // The PC already advanced when the data came back.
               addr_d  = pc_i;
               valid_d = 1'b0;
               state_d = S_WAIT;
            end
         end

`ifdef IF_FETCH_ALIGN_CHK_EN
         S_FAULT: begin
            if (br_taken_i) begin
               pc_en_o   = 1'b1;
               pc_next_o = br_target_i;
               valid_d   = 1'b0;
               fault_d   = 1'b0;
               state_d   = S_ISSUE;
            end
         end
`endif

         default: begin
            state_d = S_ISSUE;
         end
      endcase
   end

   assign imem_req_o  = (state_q == S_WAIT);
   assign imem_addr_o = addr_q;
   assign if_valid_o  = valid_q;
   assign if_instr_o  = instr_q;
   assign if_pc_o     = ifpc_q;
   assign dbg_state_o = state_q;
`ifdef IF_FETCH_ALIGN_CHK_EN
   assign if_fault_o  = fault_q;
`else
   assign if_fault_o  = 1'b0;
`endif

endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: bench for if_fetch with a PC register model, a memory model
// with programmable ack delay and an expected-instruction queue.
module tb_if_fetch;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] pc;
   logic        pc_en;
   logic [31:0] pc_next;
   logic        br_taken;
   logic [31:0] br_target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = 32'hDEAD_BEEF;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        if_fault;
   logic [1:0]  dbg_state;

   logic        pc_load;
   logic [31:0] pc_load_val;
   int          mem_delay;
   int          wait_cnt = 0;
   int          tests_run;
   int          fails;
   logic [31:0] exp_q[$];
   logic [31:0] exp_pc_q[$];

   if_fetch #(.INSTR_BYTES(4)) dut (
      .clk_i(clk), .rst_n_i(rst_n), .pc_i(pc), .pc_en_o(pc_en), .pc_next_o(pc_next),
      .br_taken_i(br_taken), .br_target_i(br_target),
      .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_ack_i(imem_ack), .imem_rdata_i(imem_rdata),
      .if_valid_o(if_valid), .if_ready_i(if_ready), .if_instr_o(if_instr), .if_pc_o(if_pc),
      .if_fault_o(if_fault), .dbg_state_o(dbg_state)
   );

   // Clock / reset block
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout exp finish");
      $fatal(1, "watchdog");
   end

   // PC register model
   always @(posedge clk) begin
      if (pc_load) pc <= pc_load_val;
      else if (pc_en) pc <= pc_next;
   end

   // Instruction memory model: ack after mem_delay waiting cycles, data = 0x1111_0000 + addr
   always @(posedge clk) begin
      #1;
      if (imem_req) begin
         if (wait_cnt >= mem_delay) begin
            imem_ack = 1'b1; imem_rdata = 32'h1111_0000 + imem_addr; wait_cnt = 0;
         end else begin
            imem_ack = 1'b0; imem_rdata = 32'hDEAD_BEEF; wait_cnt++;
         end
      end else begin
         imem_ack = 1'b0; imem_rdata = 32'hDEAD_BEEF; wait_cnt = 0;
      end
   end

   // Driver: reset the DUT with the PC model preset to pc0; returns just after release
   task automatic do_reset(input logic [31:0] pc0, input int dly);
      rst_n = 1'b0; br_taken = 1'b0; br_target = '0; if_ready = 1'b0;
      mem_delay = dly; pc_load = 1'b1; pc_load_val = pc0;
      exp_q.delete(); exp_pc_q.delete();
      repeat (2) @(posedge clk);
      #1; pc_load = 1'b0; rst_n = 1'b1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; br_taken = 1'b0; br_target = '0; if_ready = 1'b0;
      mem_delay = 0; pc_load = 1'b1; pc_load_val = 32'h10;
      @(negedge clk);
      tests_run++; if (imem_req !== 1'b0) begin fails++; $display("FAIL rst_req: got %b exp 0", imem_req); end
      tests_run++; if (if_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b exp 0", if_valid); end
      tests_run++; if (if_instr !== 32'h0) begin fails++; $display("FAIL rst_instr: got %h exp 0", if_instr); end
      tests_run++; if (if_pc !== 32'h0) begin fails++; $display("FAIL rst_pc: got %h exp 0", if_pc); end
      tests_run++; if (if_fault !== 1'b0) begin fails++; $display("FAIL rst_fault: got %b exp 0", if_fault); end
      tests_run++; if (pc_en !== 1'b0) begin fails++; $display("FAIL rst_pc_en: got %b exp 0", pc_en); end
      tests_run++; if (dbg_state !== 2'd0) begin fails++; $display("FAIL rst_state: got %0d exp 0", dbg_state); end
      @(posedge clk); #1; pc_load = 1'b0; rst_n = 1'b1;
      @(negedge clk);
      tests_run++; if (imem_req !== 1'b0) begin fails++; $display("FAIL rst_req_c1: got %b exp 0", imem_req); end
      @(negedge clk);
      tests_run++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin fails++; $display("FAIL rst_first_req: got req %b addr %h exp req 1 addr 10", imem_req, imem_addr); end
   endtask

   task automatic test_seq;
      logic [31:0] exp_addr, e_i, e_p;
      logic        exp_valid;
      do_reset(32'h0, 0);
      if_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         exp_q.push_back(32'h1111_0000 + 32'(k * 4)); exp_pc_q.push_back(32'(k * 4));
      end
      exp_addr = 32'h0;
      for (int c = 1; c <= 17; c++) begin
         @(negedge clk);
         exp_valid = (c >= 3) && (c % 2 == 1);
         tests_run++; if (if_valid !== exp_valid) begin fails++; $display("FAIL seq_valid c%0d: got %b exp %b", c, if_valid, exp_valid); end
         if (imem_req) begin
            tests_run++; if (imem_addr !== exp_addr) begin fails++; $display("FAIL seq_addr: got %h exp %h", imem_addr, exp_addr); end
            tests_run++; if (pc_en !== imem_ack || (imem_ack && pc_next !== exp_addr + 32'd4)) begin fails++; $display("FAIL seq_pc_next: got en %b next %h exp en %b next %h", pc_en, pc_next, imem_ack, exp_addr + 32'd4); end
            if (imem_ack) exp_addr += 32'd4;
         end else begin
            tests_run++; if (pc_en !== 1'b0) begin fails++; $display("FAIL seq_pc_en_idle: got %b exp 0", pc_en); end
         end
         if (if_valid && if_ready && !if_fault) begin
            tests_run++;
            if (exp_q.size() == 0) begin fails++; $display("FAIL seq_extra: got instr %h pc %h exp none", if_instr, if_pc); end
            else begin
               e_i = exp_q.pop_front(); e_p = exp_pc_q.pop_front();
               if (if_instr !== e_i || if_pc !== e_p) begin fails++; $display("FAIL seq_instr: got %h@%h exp %h@%h", if_instr, if_pc, e_i, e_p); end
            end
         end
      end
      @(posedge clk); #1; if_ready = 1'b0;
      tests_run++; if (exp_q.size() != 0) begin fails++; $display("FAIL seq_drain: got %0d left exp 0", exp_q.size()); end
   endtask

   task automatic test_stall;
      logic [31:0] e_i, e_p;
      bit got;
      int nwait;
      do_reset(32'h0, 3);
      exp_q.push_back(32'h1111_0000); exp_pc_q.push_back(32'h0);
      got = 0; nwait = 0;
      for (int c = 0; c < 20 && !got; c++) begin
         @(negedge clk);
         if (imem_req) begin
            tests_run++; if (imem_addr !== 32'h0) begin fails++; $display("FAIL stall_addr: got %h exp 0", imem_addr); end
            if (imem_ack) begin
               got = 1;
               tests_run++; if (pc_en !== 1'b1 || pc_next !== 32'h4) begin fails++; $display("FAIL stall_ack_pc: got en %b next %h exp 1 4", pc_en, pc_next); end
            end else begin
               nwait++;
               tests_run++; if (pc_en !== 1'b0) begin fails++; $display("FAIL stall_wait_pc_en: got %b exp 0", pc_en); end
            end
         end
      end
      tests_run++; if (!got || nwait != 3) begin fails++; $display("FAIL stall_ack_wait: got ack %0d waits %0d exp 1 3", got, nwait); end
      repeat (4) begin
         @(negedge clk);
         tests_run++; if (if_valid !== 1'b1 || if_instr !== 32'h1111_0000 || if_pc !== 32'h0) begin fails++; $display("FAIL stall_hold: got v %b %h@%h exp 1 11110000@0", if_valid, if_instr, if_pc); end
         tests_run++; if (pc_en !== 1'b0 || imem_req !== 1'b0) begin fails++; $display("FAIL stall_hold_quiet: got en %b req %b exp 0 0", pc_en, imem_req); end
      end
      @(posedge clk); #1; if_ready = 1'b1;
      @(negedge clk);
      tests_run++; if (pc_en !== 1'b0) begin fails++; $display("FAIL stall_accept_pc_en: got %b exp 0", pc_en); end
      tests_run++;
      if (!(if_valid && if_ready) || exp_q.size() == 0) begin fails++; $display("FAIL stall_accept: got valid %b exp 1", if_valid); end
      else begin
         e_i = exp_q.pop_front(); e_p = exp_pc_q.pop_front();
         if (if_instr !== e_i || if_pc !== e_p) begin fails++; $display("FAIL stall_instr: got %h@%h exp %h@%h", if_instr, if_pc, e_i, e_p); end
      end
      @(posedge clk); #1; if_ready = 1'b0;
      @(negedge clk);
      tests_run++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin fails++; $display("FAIL stall_next_req: got req %b addr %h exp 1 4", imem_req, imem_addr); end
   endtask

   task automatic test_br_wait;
      logic [31:0] e_i, e_p;
      bit got;
      do_reset(32'h0, 3);
      if_ready = 1'b1;
      exp_q.push_back(32'h1111_0100); exp_pc_q.push_back(32'h100);
      @(posedge clk); #1; br_taken = 1'b1; br_target = 32'h100;
      @(negedge clk);
      tests_run++; if (imem_req !== 1'b1 || imem_ack !== 1'b0) begin fails++; $display("FAIL brw_in_wait: got req %b ack %b exp 1 0", imem_req, imem_ack); end
      tests_run++; if (pc_en !== 1'b1 || pc_next !== 32'h100) begin fails++; $display("FAIL brw_pc_next: got en %b next %h exp 1 100", pc_en, pc_next); end
      @(posedge clk); #1; br_taken = 1'b0;
      got = 0;
      for (int c = 0; c < 20 && !got; c++) begin
         @(negedge clk);
         tests_run++; if (if_valid !== 1'b0) begin fails++; $display("FAIL brw_valid: got %b exp 0", if_valid); end
         if (imem_req) begin
            tests_run++; if (imem_addr !== 32'h0) begin fails++; $display("FAIL brw_addr_stable: got %h exp 0", imem_addr); end
            if (imem_ack) begin
               got = 1;
               tests_run++; if (pc_en !== 1'b0) begin fails++; $display("FAIL brw_kill_pc_en: got %b exp 0", pc_en); end
            end
         end
      end
      tests_run++; if (!got) begin fails++; $display("FAIL brw_late_ack: got none exp ack"); end
      got = 0;
      for (int c = 0; c < 20 && !got; c++) begin
         @(negedge clk);
         if (imem_req) begin
            got = 1;
            tests_run++; if (imem_addr !== 32'h100) begin fails++; $display("FAIL brw_refetch: got %h exp 100", imem_addr); end
         end else begin
            tests_run++; if (if_valid !== 1'b0) begin fails++; $display("FAIL brw_no_valid: got %b exp 0", if_valid); end
         end
      end
      tests_run++; if (!got) begin fails++; $display("FAIL brw_refetch_req: got none exp req"); end
      got = 0;
      for (int c = 0; c < 20 && !got; c++) begin
         @(negedge clk);
         if (if_valid && if_ready) begin
            got = 1;
            tests_run++;
            if (exp_q.size() == 0) begin fails++; $display("FAIL brw_extra: got %h exp none", if_instr); end
            else begin
               e_i = exp_q.pop_front(); e_p = exp_pc_q.pop_front();
               if (if_instr !== e_i || if_pc !== e_p) begin fails++; $display("FAIL brw_instr: got %h@%h exp %h@%h", if_instr, if_pc, e_i, e_p); end
            end
         end
      end
      @(posedge clk); #1; if_ready = 1'b0;
      tests_run++; if (!got || exp_q.size() != 0) begin fails++; $display("FAIL brw_drain: got %0d left exp 0", exp_q.size()); end
   endtask

   task automatic test_br_ack;
      logic [31:0] e_i, e_p;
      bit redirected, seen_req;
      do_reset(32'h0, 0);
      if_ready = 1'b1;
      exp_q.push_back(32'h1111_0000); exp_pc_q.push_back(32'h0);
      exp_q.push_back(32'h1111_0004); exp_pc_q.push_back(32'h4);
      exp_q.push_back(32'h1111_0200); exp_pc_q.push_back(32'h200);
      redirected = 0; seen_req = 0;
      for (int c = 0; c < 30 && !(redirected && exp_q.size() == 0); c++) begin
         @(posedge clk); #2;
         br_taken = 1'b0;
         if (!redirected && imem_req && imem_ack && imem_addr == 32'h8) begin
            br_taken = 1'b1; br_target = 32'h200; redirected = 1;
         end
         @(negedge clk);
         if (br_taken) begin
            tests_run++; if (pc_en !== 1'b1 || pc_next !== 32'h200) begin fails++; $display("FAIL bra_pc_next: got en %b next %h exp 1 200", pc_en, pc_next); end
         end else if (redirected && imem_req && !seen_req) begin
            seen_req = 1;
            tests_run++; if (imem_addr !== 32'h200) begin fails++; $display("FAIL bra_next_addr: got %h exp 200", imem_addr); end
         end
         if (if_valid && if_ready) begin
            tests_run++;
            if (exp_q.size() == 0) begin fails++; $display("FAIL bra_extra: got %h@%h exp none", if_instr, if_pc); end
            else begin
               e_i = exp_q.pop_front(); e_p = exp_pc_q.pop_front();
               if (if_instr !== e_i || if_pc !== e_p) begin fails++; $display("FAIL bra_instr: got %h@%h exp %h@%h", if_instr, if_pc, e_i, e_p); end
            end
         end
      end
      @(posedge clk); #1; br_taken = 1'b0; if_ready = 1'b0;
      tests_run++; if (!redirected || !seen_req || exp_q.size() != 0) begin fails++; $display("FAIL bra_done: got redir %0d req %0d left %0d exp 1 1 0", redirected, seen_req, exp_q.size()); end
   endtask

   task automatic test_async_rst;
      logic [31:0] e_i, e_p;
      bit got;
      do_reset(32'h40, 2);
      if_ready = 1'b1;
      exp_q.push_back(32'h1111_0040); exp_pc_q.push_back(32'h40);
      got = 0;
      for (int c = 0; c < 20 && !got; c++) begin
         @(negedge clk);
         if (if_valid && if_ready) begin
            got = 1;
            e_i = exp_q.pop_front(); e_p = exp_pc_q.pop_front();
            tests_run++; if (if_instr !== e_i || if_pc !== e_p) begin fails++; $display("FAIL arst_first: got %h@%h exp %h@%h", if_instr, if_pc, e_i, e_p); end
         end
      end
      tests_run++; if (!got) begin fails++; $display("FAIL arst_first_hs: got none exp handshake"); end
      @(posedge clk); #3;
      tests_run++; if (imem_req !== 1'b1 || imem_addr !== 32'h44) begin fails++; $display("FAIL arst_pre: got req %b addr %h exp 1 44", imem_req, imem_addr); end
      rst_n = 1'b0;
      #1;
      tests_run++; if (imem_req !== 1'b0 || if_valid !== 1'b0) begin fails++; $display("FAIL arst_drop: got req %b valid %b exp 0 0", imem_req, if_valid); end
      tests_run++; if (if_instr !== 32'h0 || if_pc !== 32'h0) begin fails++; $display("FAIL arst_regs: got %h@%h exp 0@0", if_instr, if_pc); end
      @(posedge clk); #1; rst_n = 1'b1; if_ready = 1'b0;
      @(negedge clk);
      tests_run++; if (imem_req !== 1'b0) begin fails++; $display("FAIL arst_c1: got req %b exp 0", imem_req); end
      @(negedge clk);
      tests_run++; if (imem_req !== 1'b1 || imem_addr !== 32'h44) begin fails++; $display("FAIL arst_restart: got req %b addr %h exp 1 44", imem_req, imem_addr); end
   endtask

   task automatic test_wrap;
      do_reset(32'hFFFF_FFFC, 0);
      @(negedge clk);
      @(negedge clk);
      tests_run++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC || imem_ack !== 1'b1) begin fails++; $display("FAIL wrap_req: got req %b addr %h exp 1 fffffffc", imem_req, imem_addr); end
      tests_run++; if (pc_en !== 1'b1 || pc_next !== 32'h0) begin fails++; $display("FAIL wrap_pc_next: got en %b next %h exp 1 0", pc_en, pc_next); end
      @(negedge clk);
      tests_run++; if (if_valid !== 1'b1 || if_instr !== 32'h1110_FFFC || if_pc !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_out: got v %b %h@%h exp 1 1110fffc@fffffffc", if_valid, if_instr, if_pc); end
   endtask

   task automatic test_align;
`ifndef IF_FETCH_ALIGN_CHK_EN
      logic [31:0] e_i, e_p;
      bit got;
`endif
      do_reset(32'h0, 0);
      if_ready = 1'b1;
      br_taken = 1'b1; br_target = 32'h102;
      @(negedge clk);
      tests_run++; if (pc_en !== 1'b1 || pc_next !== 32'h102 || imem_req !== 1'b0) begin fails++; $display("FAIL algn_redirect: got en %b next %h req %b exp 1 102 0", pc_en, pc_next, imem_req); end
      @(posedge clk); #1; br_taken = 1'b0;
`ifdef IF_FETCH_ALIGN_CHK_EN
      @(negedge clk);
      tests_run++; if (imem_req !== 1'b0 || if_valid !== 1'b0) begin fails++; $display("FAIL algn_issue: got req %b valid %b exp 0 0", imem_req, if_valid); end
      repeat (4) begin
         @(negedge clk);
         tests_run++; if (imem_req !== 1'b0 || pc_en !== 1'b0) begin fails++; $display("FAIL algn_quiet: got req %b en %b exp 0 0", imem_req, pc_en); end
         tests_run++; if (if_valid !== 1'b1 || if_fault !== 1'b1 || if_pc !== 32'h102 || if_instr !== 32'h0) begin fails++; $display("FAIL algn_fault: got v %b f %b %h@%h exp 1 1 0@102", if_valid, if_fault, if_instr, if_pc); end
      end
      @(posedge clk); #1; br_taken = 1'b1; br_target = 32'h200;
      @(negedge clk);
      tests_run++; if (pc_en !== 1'b1 || pc_next !== 32'h200) begin fails++; $display("FAIL algn_exit: got en %b next %h exp 1 200", pc_en, pc_next); end
      @(posedge clk); #1; br_taken = 1'b0;
      @(negedge clk);
      tests_run++; if (if_valid !== 1'b0 || if_fault !== 1'b0 || imem_req !== 1'b0) begin fails++; $display("FAIL algn_clear: got v %b f %b req %b exp 0 0 0", if_valid, if_fault, imem_req); end
      @(negedge clk);
      tests_run++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin fails++; $display("FAIL algn_resume: got req %b addr %h exp 1 200", imem_req, imem_addr); end
`else
      exp_q.push_back(32'h1111_0102); exp_pc_q.push_back(32'h102);
      got = 0;
      for (int c = 0; c < 20 && !got; c++) begin
         @(negedge clk);
         tests_run++; if (if_fault !== 1'b0) begin fails++; $display("FAIL algn_nofault: got %b exp 0", if_fault); end
         if (imem_req) begin
            tests_run++; if (imem_addr !== 32'h102) begin fails++; $display("FAIL algn_pass_addr: got %h exp 102", imem_addr); end
         end
         if (if_valid && if_ready) begin
            got = 1;
            e_i = exp_q.pop_front(); e_p = exp_pc_q.pop_front();
            tests_run++; if (if_instr !== e_i || if_pc !== e_p) begin fails++; $display("FAIL algn_instr: got %h@%h exp %h@%h", if_instr, if_pc, e_i, e_p); end
         end
      end
      tests_run++; if (!got) begin fails++; $display("FAIL algn_hs: got none exp handshake"); end
`endif
      if_ready = 1'b0;
   endtask

   initial begin
      tests_run = 0; fails = 0;
      pc_load = 1'b0; pc_load_val = '0; mem_delay = 0;
      br_taken = 1'b0; br_target = '0; if_ready = 1'b0;
      test_reset;
      test_seq;
      test_stall;
      test_br_wait;
      test_br_ack;
      test_async_rst;
      test_wrap;
      test_align;
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage that drives the PC register's update inputs (PC_EN, PC_NEXT) and consumes its current value (PC).
- Issues word requests to instruction memory over a REQ/ACK handshake.
- Holds the returned instruction in an output register and presents it to decode with a VALID/READY handshake.
- Accepts a redirect from execute (taken branch/jump) and squashes any wrong-path fetch.

Parameters:
INSTR_BYTES, 4, PC increment per sequential fetch (byte-addressed, 32-bit instructions)

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  asynchronous active-low reset
PC  in  32  current PC from the PC register
PC_EN  out  1  PC update strobe to the PC register (combinational)
PC_NEXT  out  32  next PC value (combinational; meaningful only when PC_EN=1)
BR_TAKEN  in  1  redirect request from execute, single-cycle pulse
BR_TARGET  in  32  redirect address, valid with BR_TAKEN
IMEM_REQ  out  1  fetch request; held until IMEM_ACK
IMEM_ADDR  out  32  fetch address; stable while IMEM_REQ=1
IMEM_ACK  in  1  memory response; IMEM_RDATA valid in the same cycle
IMEM_RDATA  in  32  fetched instruction word
IF_VALID  out  1  instruction valid to decode
IF_READY  in  1  decode accepts the instruction
IF_INSTR  out  32  registered instruction
IF_PC  out  32  address of IF_INSTR
IF_FAULT  out  1  misaligned-fetch flag (see Optional Feature)

Behaviour:
- Registers:
  - State in {ISSUE, WAIT, HOLD, FAULT}.
  - addr_q[31:0], kill_q, and the IF_* output registers.
- Async reset (RST_N=0):
  - state=ISSUE; addr_q=0; kill_q=0.
  - IF_VALID=0, IF_INSTR=0, IF_PC=0, IF_FAULT=0.
  - IMEM_REQ=0 (decoded from state).
  - Reset mid-request abandons the request. Instruction memory must tolerate REQ dropping without ACK.
- Outputs:
  - IMEM_REQ=1 iff state=WAIT.
  - IMEM_ADDR=addr_q.
  - IF_VALID=1 in HOLD and FAULT.
- ISSUE:
  - No BR_TAKEN: addr_q<=PC, go WAIT.
  - BR_TAKEN: PC_EN=1, PC_NEXT=BR_TARGET, stay ISSUE. The PC is changing at this edge, so it is not latched.
- WAIT:
  - ACK with kill_q=0 and no BR_TAKEN:
    - IF_INSTR<=IMEM_RDATA, IF_PC<=addr_q.
    - PC_EN=1, PC_NEXT=addr_q+INSTR_BYTES (mod 2^32; wraps 0xFFFF_FFFC -> 0x0000_0000).
    - Go HOLD.
  - ACK with kill_q=1 or BR_TAKEN: discard data, clear kill_q, go ISSUE.
    - If BR_TAKEN: PC_EN=1, PC_NEXT=BR_TARGET.
  - No ACK, BR_TAKEN:
    - PC_EN=1, PC_NEXT=BR_TARGET, kill_q<=1.
    - Stay WAIT with IMEM_ADDR unchanged.
  - Multiple redirects while waiting: each updates the PC; kill_q stays 1.
- HOLD:
  - BR_TAKEN: PC_EN=1, PC_NEXT=BR_TARGET, IF_VALID<=0, go ISSUE.
    - If IF_READY=1 in the same cycle, the handshake still completes. Downstream flushing is execute's responsibility.
  - Else IF_READY=1: addr_q<=PC (already advanced), IF_VALID<=0, go WAIT.
  - Else hold all outputs stable.
- PC_EN=0 in every case not listed above.
- Only one PC_EN source per cycle. BR_TAKEN has priority over sequential increment.
- Latency and throughput:
  - Reset to first IMEM_REQ: 1 cycle.
  - ACK to IF_VALID: 1 cycle.
  - Sustained rate: 1 instruction per 2 cycles with zero-wait memory and IF_READY tied 1.

Optional Feature:
- Macro IF_FETCH_ALIGN_CHK_EN.
- Defined: on any transition that would enter WAIT (from ISSUE or HOLD), if PC[1:0]!=0:
  - No request is issued. Go FAULT with IF_FAULT<=1, IF_INSTR<=0, IF_PC<=PC; PC_EN=0.
  - FAULT holds IF_VALID=1 regardless of IF_READY.
  - FAULT exits only on BR_TAKEN: PC_NEXT=BR_TARGET, PC_EN=1, IF_VALID<=0, IF_FAULT<=0, go ISSUE.
- Undefined: FAULT state is absent, IF_FAULT is tied 0, and PC[1:0] is ignored (address passed through).

Test Plan:
- Reset, PC model reset 0x0, zero-wait ACK returning 0x1111_0000+addr, IF_READY=1 -> IMEM_ADDR sequence 0x0,0x4,0x8,...; IF_INSTR 0x1111_0000, 0x1111_0004, ...; one PC_EN per fetch; IF_VALID every 2nd cycle.
- ACK delayed 3 cycles, IF_READY held 0 for 4 cycles in HOLD -> IMEM_ADDR stable during WAIT; IF_INSTR/IF_PC stable; no PC_EN during stall.
- BR_TAKEN target 0x100 in WAIT cycle 1 before a late ACK -> PC_NEXT=0x100 that cycle; late data discarded (IF_VALID stays 0); next request at 0x100.
- BR_TAKEN coincident with ACK at addr 0x8 -> PC_NEXT=0x200 not 0xC; no IF_VALID for 0x8; next IMEM_ADDR 0x200.
- RST_N asserted asynchronously mid-WAIT -> IMEM_REQ and IF_VALID fall immediately; IF_INSTR=0; after release, request restarts at current PC.
- With IF_FETCH_ALIGN_CHK_EN, redirect to 0x102 -> no IMEM_REQ; IF_VALID=1, IF_FAULT=1, IF_PC=0x102; remains until BR_TAKEN to 0x200, then fetch resumes at 0x200.
